// File: rtl/shift_deserializer_pkg.sv
// shift_pkg: types shared by the shift-out and shift-in paths.
//   shift_mode_e   : 2-bit link mode (clear / hold / MSB-first / LSB-first)
//   deser_state_e  : output-buffer state of the deserializer
//   frame_len()    : serial bits per frame, including the parity bit when
//                    SHIFT_DESER_PARITY_EN is defined
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_CLEAR     = 2'b00,
    MODE_HOLD      = 2'b01,
    MODE_MSB_FIRST = 2'b10,
    MODE_LSB_FIRST = 2'b11
  } shift_mode_e;

  typedef enum logic {ST_COLLECT, ST_PRESENT} deser_state_e;

  function automatic int frame_len(input int width);
`ifdef SHIFT_DESER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/shift_deserializer_if.sv
// shift_deser_if: parallel word output of the deserializer.
//   data_out   : completed word
//   word_valid : data_out holds an unaccepted word
//   word_ready : consumer accepts on word_valid && word_ready
//   parity_err : (SHIFT_DESER_PARITY_EN only) parity check of the word
// Modports: master = deserializer, slave = consumer.
interface shift_deser_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data_out;
  logic             word_valid;
  logic             word_ready;
`ifdef SHIFT_DESER_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    output data_out, word_valid,
`ifdef SHIFT_DESER_PARITY_EN
    output parity_err,
`endif
    input  word_ready
  );

  modport slave (
    input  data_out, word_valid,
`ifdef SHIFT_DESER_PARITY_EN
    input  parity_err,
`endif
    output word_ready
  );
endinterface

// File: rtl/shift_deser_buf.sv
// shift_deser_buf: one-entry output buffer with valid/ready handshake and
// sticky overrun detection.
//   clk, reset  : clock, async active-low reset
//   clear       : synchronous clear of the whole buffer (mode 00)
//   load        : a completed word is offered on load_data this edge
//   load_data   : completed word
//   word_ready  : consumer ready
//   data_out, word_valid, overrun : buffer outputs (all registered)
//   load_perr / parity_err        : SHIFT_DESER_PARITY_EN only
//
// state      | meaning
// ST_COLLECT | buffer empty, word_valid = 0
// ST_PRESENT | buffer holds an unaccepted word, word_valid = 1
module shift_deser_buf import shift_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
`ifdef SHIFT_DESER_PARITY_EN
  input  logic             load_perr,
  output logic             parity_err,
`endif
  input  logic             word_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             word_valid,
  output logic             overrun
);

  deser_state_e state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_COLLECT;
      data_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (clear) begin
      state      <= ST_COLLECT;
      data_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_COLLECT: begin
          if (load) begin
            data_out   <= load_data;
`ifdef SHIFT_DESER_PARITY_EN
            parity_err <= load_perr;
`endif
            word_valid <= 1'b1;
            state      <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // word_valid is 1 here, so word_ready alone means accept
          if (load && word_ready) begin
            data_out   <= load_data;
`ifdef SHIFT_DESER_PARITY_EN
            parity_err <= load_perr;
`endif
          end else if (load) begin
            overrun <= 1'b1;
          end else if (word_ready) begin
            word_valid <= 1'b0;
            state      <= ST_COLLECT;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-to-parallel receiver, MSB- or LSB-first.
// Optional macro: SHIFT_DESER_PARITY_EN adds a trailing even-parity bit per
// frame and a parity_err output on the interface.
//   clk, reset  : clock, async active-low reset
//   mode        : 00 clear, 01 hold, 10 MSB-first, 11 LSB-first
//   serial_in   : serial data bit, sampled when bit_valid and receiving
//   bit_valid   : bit strobe
//   bit_count   : bits currently held in the assembly register
//   overrun     : sticky, a completed word was dropped
//   out_if      : word output (data_out / word_valid / word_ready)
module shift_deserializer import shift_pkg::*; #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(frame_len(WIDTH) + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic             bit_valid,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun,
  shift_deser_if.master    out_if
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(frame_len(WIDTH));

  shift_mode_e      mode_e;
  logic [WIDTH-1:0] asm_q, asm_base, asm_next, word;
  logic [CNT_W-1:0] cnt_base, cnt_next;
  logic             dir_lsb_q;
  logic             rx_mode, rx_lsb, dir_switch, take, complete;

  assign mode_e  = shift_mode_e'(mode);
  assign rx_mode = (mode_e == MODE_MSB_FIRST) || (mode_e == MODE_LSB_FIRST);
  assign rx_lsb  = (mode_e == MODE_LSB_FIRST);
  // dir_lsb_q remembers the last receive direction so that a hold in
  // between keeps the partial word, while a real 10<->11 change drops it.
  assign dir_switch = rx_mode && (rx_lsb != dir_lsb_q) && (bit_count != '0);
  assign take       = rx_mode && bit_valid;

  always_comb begin
    asm_base = dir_switch ? '0 : asm_q;
    cnt_base = dir_switch ? '0 : bit_count;
    asm_next = asm_base;
    cnt_next = cnt_base;
    if (take) begin
`ifdef SHIFT_DESER_PARITY_EN
      // the trailing parity bit is counted but not shifted into the word
      if (cnt_base < CNT_W'(WIDTH))
`endif
        asm_next = rx_lsb ? {serial_in, asm_base[WIDTH-1:1]}
                          : {asm_base[WIDTH-2:0], serial_in};
      cnt_next = cnt_base + 1'b1;
    end
  end

  assign complete = take && (cnt_next == FRAME_CNT);

`ifdef SHIFT_DESER_PARITY_EN
  logic perr;
  assign word = asm_base;
  assign perr = ^asm_base ^ serial_in;
`else
  assign word = asm_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_q     <= '0;
      bit_count <= '0;
      dir_lsb_q <= 1'b0;
    end else if (mode_e == MODE_CLEAR) begin
      asm_q     <= '0;
      bit_count <= '0;
    end else if (rx_mode) begin
      dir_lsb_q <= rx_lsb;
      if (complete) begin
        asm_q     <= '0;
        bit_count <= '0;
      end else begin
        asm_q     <= asm_next;
        bit_count <= cnt_next;
      end
    end
  end

  shift_deser_buf #(.WIDTH(WIDTH)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .clear      (mode_e == MODE_CLEAR),
    .load       (complete),
    .load_data  (word),
`ifdef SHIFT_DESER_PARITY_EN
    .load_perr  (perr),
    .parity_err (out_if.parity_err),
`endif
    .word_ready (out_if.word_ready),
    .data_out   (out_if.data_out),
    .word_valid (out_if.word_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_shift_deserializer.sv
// Testbench for shift_deserializer: directed scenarios plus randomized
// traffic, all checked against a bit-list reference model.
module tb_shift_deserializer;
  import shift_pkg::*;

  localparam int W     = 8;
  localparam int FRAME = frame_len(W);
  localparam int CW    = $clog2(FRAME + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic          serial_in;
  logic          bit_valid;
  logic [CW-1:0] bit_count;
  logic          overrun;

  shift_deser_if #(.WIDTH(W)) bus ();

  shift_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .serial_in (serial_in),
    .bit_valid (bit_valid),
    .bit_count (bit_count),
    .overrun   (overrun),
    .out_if    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: received bits of the current frame, buffer contents
  bit       m_bits[$];
  bit       m_lsb;
  bit       m_valid;
  bit [W-1:0] m_data;
  bit       m_ovr;
  bit       m_perr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_lsb   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
  endtask

  // one clock edge of the reference behaviour, from the pre-edge state
  task automatic model_edge(input logic [1:0] md, input logic sin, input logic bv, input logic rdy);
    bit         accept, done, par;
    bit [W-1:0] w;
    accept = m_valid && rdy;
    done   = 1'b0;
    w      = '0;
    par    = 1'b0;
    if (md == 2'b00) begin
      model_reset();
    end else begin
      if (md[1]) begin
        if (m_bits.size() != 0 && md[0] != m_lsb) m_bits.delete();
        m_lsb = md[0];
        if (bv) begin
          m_bits.push_back(sin);
          if (m_bits.size() == FRAME) begin
            for (int i = 0; i < W; i++) begin
              if (m_lsb) w[i] = m_bits[i];
              else       w[W-1-i] = m_bits[i];
            end
            for (int i = 0; i < FRAME; i++) par = par ^ m_bits[i];
            m_bits.delete();
            done = 1'b1;
          end
        end
      end
      if (done) begin
        if (!m_valid || accept) begin
          m_data  = w;
          m_valid = 1'b1;
          m_perr  = par;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (accept) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},  32'(bus.data_out),  32'(m_data));
    check({tag, ".valid"}, 32'(bus.word_valid), 32'(m_valid));
    check({tag, ".count"}, 32'(bit_count),      32'(m_bits.size()));
    check({tag, ".ovr"},   32'(overrun),        32'(m_ovr));
`ifdef SHIFT_DESER_PARITY_EN
    if (m_valid) check({tag, ".perr"}, 32'(bus.parity_err), 32'(m_perr));
`endif
  endtask

  // called at a falling edge; drives, lets one rising edge pass, checks
  task automatic step(input string tag, input logic [1:0] md, input logic sin,
                      input logic bv, input logic rdy);
    mode = md; serial_in = sin; bit_valid = bv; bus.word_ready = rdy;
    @(posedge clk);
    model_edge(md, sin, bv, rdy);
    @(negedge clk);
    check_all(tag);
  endtask

  // sends pat[n-1] first down to pat[0]
  task automatic send_seq(input string tag, input logic [1:0] md, input logic [15:0] pat,
                          input int n, input logic rdy);
    for (int i = n - 1; i >= 0; i--) step(tag, md, pat[i], 1'b1, rdy);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0] md;
    logic       dir;
    int         r;
    reset = 1'b0; mode = 2'b00; serial_in = 1'b0; bit_valid = 1'b0; bus.word_ready = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // MSB-first 1,0,1,1,0,0,1,0
    send_seq("msb", 2'b10, 16'hB2, 8, 1'b1);
`ifndef SHIFT_DESER_PARITY_EN
    check("msb_word", 32'(bus.data_out), 32'h00B2);
    check("msb_valid", 32'(bus.word_valid), 32'd1);
    check("msb_count", 32'(bit_count), 32'd0);
`endif
    // same bits LSB-first
    send_seq("lsb", 2'b11, 16'hB2, 8, 1'b1);
`ifndef SHIFT_DESER_PARITY_EN
    check("lsb_word", 32'(bus.data_out), 32'h004D);
`endif
    step("drain", 2'b01, 1'b0, 1'b0, 1'b1);

    // overrun: A5 kept, 3C dropped, then clear
    send_seq("ovr", 2'b10, 16'hA53C, 16, 1'b0);
`ifndef SHIFT_DESER_PARITY_EN
    check("ovr_word", 32'(bus.data_out), 32'h00A5);
    check("ovr_flag", 32'(overrun), 32'd1);
`endif
    step("clr", 2'b00, 1'b1, 1'b1, 1'b0);
    check("clr_valid", 32'(bus.word_valid), 32'd0);
    check("clr_ovr", 32'(overrun), 32'd0);
    check("clr_data", 32'(bus.data_out), 32'd0);

    // back-to-back: second word completes on the same edge it is accepted
    send_seq("b2b1", 2'b10, 16'hFF, 8, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      step("b2b2", 2'b10, (i == 0), 1'b1, (i == 0));
      check("b2b_valid", 32'(bus.word_valid), 32'd1);
    end
`ifndef SHIFT_DESER_PARITY_EN
    check("b2b_word", 32'(bus.data_out), 32'h0001);
`endif
    check("b2b_ovr", 32'(overrun), 32'd0);
    step("drain", 2'b01, 1'b0, 1'b0, 1'b1);

    // direction switch drops the partial word
    send_seq("sw_a", 2'b10, 16'h5, 3, 1'b1);
    send_seq("sw_b", 2'b11, 16'h81, 8, 1'b1);
`ifndef SHIFT_DESER_PARITY_EN
    check("switch_word", 32'(bus.data_out), 32'h0081);
`endif
    // hold keeps the partial word
    send_seq("hold_a", 2'b10, 16'h5, 3, 1'b1);
    for (int i = 0; i < 5; i++) step("hold", 2'b01, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    check("hold_count", 32'(bit_count), 32'd3);
    send_seq("hold_b", 2'b10, 16'h12, 5, 1'b1);
`ifndef SHIFT_DESER_PARITY_EN
    check("hold_word", 32'(bus.data_out), 32'h00B2);
`endif

    // async reset mid-word and mid-handshake
    send_seq("rst_a", 2'b10, 16'h1B, 5, 1'b0);
    check("rst_pre_count", 32'(bit_count), 32'd5);
    async_reset("rst_mid");
    send_seq("rst_b", 2'b11, 16'hC3, FRAME, 1'b0);
    check("rst_pre_valid", 32'(bus.word_valid), 32'd1);
    async_reset("rst_hs");

    // randomized traffic
    dir = 1'b0;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if (r == 0)      md = 2'b00;
      else if (r < 5)  md = 2'b01;
      else             md = {1'b1, dir};
      step("rand", md, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
